// File: rtl/adc_sample_filter.sv
// adc_sample_filter: moving average over 2^LOG2_N ADC samples with hysteresis level flag.
// Optional ADC_PEAK_HOLD_EN adds a clearable peak-hold of raw samples.
module adc_sample_filter #(
  parameter int          LOG2_N    = 3,
  parameter logic [11:0] THRESH_HI = 12'd2458,
  parameter logic [11:0] THRESH_LO = 12'd1638
) (
  input  logic        ADC_sclk,
  input  logic        reset,
  input  logic [11:0] sample,
  input  logic        sample_valid,
  output logic [11:0] avg,
  output logic        avg_valid,
  output logic        level_high,
  output logic        primed
`ifdef ADC_PEAK_HOLD_EN
  ,
  input  logic        peak_clear,
  output logic [11:0] peak
`endif
);
  localparam int N  = 1 << LOG2_N;
  localparam int SW = 12 + LOG2_N;
  typedef enum logic {FILL, RUN} state_t;
  state_t            state_q, state_d;
  logic [LOG2_N-1:0] wr_ptr_q, wr_ptr_d;
  logic [SW-1:0]     sum_q, sum_d;
  logic [11:0]       avg_q, avg_d, oldest;
  logic              avg_valid_q, avg_valid_d, level_q, level_d;
  logic [11:0]       mem_q [N];
  // While filling, the write pointer doubles as the fill count.
  always_comb begin
    oldest      = mem_q[wr_ptr_q];
    sum_d       = sample_valid ? sum_q + {{LOG2_N{1'b0}}, sample}
                  - (state_q == RUN ? {{LOG2_N{1'b0}}, oldest} : '0) : sum_q;
    wr_ptr_d    = sample_valid ? wr_ptr_q + 1'b1 : wr_ptr_q;
    state_d     = (sample_valid && state_q == FILL && wr_ptr_q == LOG2_N'(N - 1)) ? RUN : state_q;
    avg_d       = sample_valid ? sum_d[SW-1:LOG2_N] : avg_q;
    avg_valid_d = sample_valid;
    level_d     = !sample_valid ? level_q :
                  avg_d >= THRESH_HI ? 1'b1 :
                  avg_d <= THRESH_LO ? 1'b0 : level_q;
  end
  always_ff @(posedge ADC_sclk or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      wr_ptr_q    <= '0;
      sum_q       <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      level_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      sum_q       <= sum_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      level_q     <= level_d;
    end
  end
  always_ff @(posedge ADC_sclk) begin
    if (sample_valid) mem_q[wr_ptr_q] <= sample;
  end
  assign avg        = avg_q;
  assign avg_valid  = avg_valid_q;
  assign level_high = level_q;
  assign primed     = state_q == RUN;
`ifdef ADC_PEAK_HOLD_EN
  logic [11:0] peak_q, peak_d;
  always_comb begin
    peak_d = (sample_valid && (peak_clear || sample > peak_q)) ? sample :
             peak_clear ? '0 : peak_q;
  end
  always_ff @(posedge ADC_sclk or posedge reset) begin
    if (reset) peak_q <= '0;
    else       peak_q <= peak_d;
  end
  assign peak = peak_q;
`endif
endmodule
